// File: rtl/vip_edge_bbox.sv
// rtl/vip_edge_bbox.sv - binarise Sobel magnitude, forward binary video, collect per-frame edge bounding box
module vip_edge_bbox #(
  parameter  int BITS       = 8,
  parameter  int WIDTH      = 640,
  parameter  int HEIGHT     = 480,
  parameter  int DEF_THRESH = 64,
  localparam int XW         = $clog2(WIDTH),
  localparam int YW         = $clog2(HEIGHT),
  localparam int CW         = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_data,
  input  logic [BITS-1:0] thresh,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_data,
  output logic            bbox_valid,
  output logic            bbox_empty,
  output logic [XW-1:0]   bbox_x0,
  output logic [XW-1:0]   bbox_x1,
  output logic [YW-1:0]   bbox_y0,
  output logic [YW-1:0]   bbox_y1,
  output logic [CW-1:0]   edge_count
);

  localparam logic [XW-1:0]   X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST = YW'(HEIGHT - 1);
  localparam logic [CW-1:0]   C_MAX  = CW'(WIDTH * HEIGHT);
  localparam logic [BITS-1:0] TH_RST = BITS'(DEF_THRESH);

  logic [BITS-1:0] th_q;
  logic            vs_q;
  logic            hr_q;
  logic            vs_rise;
  logic            hr_fall;
  logic            pix_act;
  logic            edge_hit;
  logic            stat_hit;

  logic [XW-1:0]   x;
  logic            x_past;
  logic [YW-1:0]   y;

  logic [CW-1:0]   count_acc;
  logic            found;
  logic [XW-1:0]   ax0;
  logic [XW-1:0]   ax1;
  logic [YW-1:0]   ay0;
  logic [YW-1:0]   ay1;

  assign vs_rise  = in_vsync & ~vs_q;
  assign hr_fall  = ~in_href & hr_q;
  assign pix_act  = in_href & ~in_vsync;
  assign edge_hit = (in_data >= th_q);
  // x_past marks pixels beyond the last column: still forwarded, never counted
  assign stat_hit = pix_act & ~x_past & edge_hit;

  assign out_href  = hr_q;
  assign out_vsync = vs_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q     <= 1'b0;
      vs_q     <= 1'b0;
      out_data <= '0;
    end else begin
      hr_q     <= in_href;
      vs_q     <= in_vsync;
      out_data <= (in_href & edge_hit) ? '1 : '0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      th_q <= TH_RST;
    end else if (vs_rise) begin
      th_q <= thresh;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      x_past <= 1'b0;
    end else if (vs_rise || hr_fall) begin
      x      <= '0;
      x_past <= 1'b0;
    end else if (pix_act) begin
      if (x == X_LAST) begin
        x_past <= 1'b1;
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // vs_rise clears y even when an hr_fall lands in the same cycle
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (vs_rise) begin
      y <= '0;
    end else if (hr_fall && !in_vsync && y != Y_LAST) begin
      y <= y + YW'(1);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      count_acc <= '0;
      found     <= 1'b0;
      ax0       <= '0;
      ax1       <= '0;
      ay0       <= '0;
      ay1       <= '0;
    end else if (vs_rise) begin
      count_acc <= '0;
      found     <= 1'b0;
      ax0       <= '0;
      ax1       <= '0;
      ay0       <= '0;
      ay1       <= '0;
    end else if (stat_hit) begin
      if (count_acc != C_MAX) begin
        count_acc <= count_acc + CW'(1);
      end
      found <= 1'b1;
      if (!found) begin
        ax0 <= x;
        ax1 <= x;
        ay0 <= y;
        ay1 <= y;
      end else begin
        if (x < ax0) ax0 <= x;
        if (x > ax1) ax1 <= x;
        if (y < ay0) ay0 <= y;
        if (y > ay1) ay1 <= y;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_valid <= 1'b0;
      bbox_empty <= 1'b1;
      bbox_x0    <= '0;
      bbox_x1    <= '0;
      bbox_y0    <= '0;
      bbox_y1    <= '0;
      edge_count <= '0;
    end else begin
      bbox_valid <= vs_rise;
      if (vs_rise) begin
        bbox_empty <= ~found;
        bbox_x0    <= found ? ax0 : '0;
        bbox_x1    <= found ? ax1 : '0;
        bbox_y0    <= found ? ay0 : '0;
        bbox_y1    <= found ? ay1 : '0;
        edge_count <= count_acc;
      end
    end
  end

endmodule

// File: tb/tb_vip_edge_bbox.sv
// tb/tb_vip_edge_bbox.sv - directed and random frames against a frame-level edge/bbox model
module tb_vip_edge_bbox;
  localparam int BITS   = 8;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int DEF_TH = 64;
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int CW     = $clog2(WIDTH * HEIGHT + 1);

  logic            pclk = 1'b0;
  logic            rst_n;
  logic            in_href;
  logic            in_vsync;
  logic [BITS-1:0] in_data;
  logic [BITS-1:0] thresh;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_data;
  logic            bbox_valid;
  logic            bbox_empty;
  logic [XW-1:0]   bbox_x0;
  logic [XW-1:0]   bbox_x1;
  logic [YW-1:0]   bbox_y0;
  logic [YW-1:0]   bbox_y1;
  logic [CW-1:0]   edge_count;

  vip_edge_bbox #(
    .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEF_THRESH(DEF_TH)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
    .in_data(in_data), .thresh(thresh), .out_href(out_href), .out_vsync(out_vsync),
    .out_data(out_data), .bbox_valid(bbox_valid), .bbox_empty(bbox_empty),
    .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1),
    .edge_count(edge_count)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // reference state: threshold in force, previous vsync, and the frame picture
  logic [7:0] m_th;
  logic       m_vs_q;
  logic [7:0] pix [0:3][0:15];
  int         len [0:3];
  int         e_cnt, e_x0, e_x1, e_y0, e_y1;
  bit         e_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] exp_d;
    logic       exp_v;
    exp_d = (in_href && in_data >= m_th) ? 8'hff : 8'h00;
    exp_v = in_vsync && !m_vs_q;
    @(posedge pclk);
    #1;
    chk("out_href", out_href, in_href);
    chk("out_vsync", out_vsync, in_vsync);
    chk("out_data", out_data, exp_d);
    chk("bbox_valid", bbox_valid, exp_v);
    if (exp_v) m_th = thresh;
    m_vs_q = in_vsync;
  endtask

  task automatic expect_frame(input int nl, input logic [7:0] f_th);
    e_cnt = 0; e_empty = 1;
    e_x0 = 0; e_x1 = 0; e_y0 = 0; e_y1 = 0;
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < len[l] && c < WIDTH; c++) begin
        if (pix[l][c] >= f_th) begin
          if (e_empty) begin
            e_x0 = c; e_x1 = c; e_y0 = l; e_y1 = l;
          end else begin
            if (c < e_x0) e_x0 = c;
            if (c > e_x1) e_x1 = c;
            if (l < e_y0) e_y0 = l;
            if (l > e_y1) e_y1 = l;
          end
          e_empty = 0;
          e_cnt++;
        end
      end
    end
  endtask

  task automatic chk_stats(input string pfx);
    chk({pfx, "_empty"}, bbox_empty, e_empty);
    chk({pfx, "_x0"}, bbox_x0, e_x0);
    chk({pfx, "_x1"}, bbox_x1, e_x1);
    chk({pfx, "_y0"}, bbox_y0, e_y0);
    chk({pfx, "_y1"}, bbox_y1, e_y1);
    chk({pfx, "_count"}, edge_count, e_cnt);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int l = 0; l < 4; l++) begin
      len[l] = WIDTH;
      for (int c = 0; c < 16; c++) pix[l][c] = v;
    end
  endtask

  task automatic send_lines(input int first, input int last);
    for (int l = first; l <= last; l++) begin
      for (int c = 0; c < len[l]; c++) begin
        in_href = 1'b1; in_data = pix[l][c]; step();
      end
      in_href = 1'b0;
      for (int g = 0; g < 3; g++) begin
        in_data = 8'($urandom); step();
      end
    end
  endtask

  // tight: last line's href falls in the vs_rise cycle; bpix: href high in that cycle
  task automatic send_frame(input int nl, input int chg_line, input logic [7:0] chg_th,
                            input bit tight, input bit bpix);
    logic [7:0] f_th;
    f_th = m_th;
    in_vsync = 1'b0;
    for (int l = 0; l < nl; l++) begin
      if (l == chg_line) thresh = chg_th;
      for (int c = 0; c < len[l]; c++) begin
        in_href = 1'b1; in_data = pix[l][c]; step();
      end
      if (!(tight && l == nl - 1)) begin
        in_href = 1'b0;
        for (int g = 0; g < 3; g++) begin
          in_data = 8'($urandom); step();
        end
      end
    end
    expect_frame(nl, f_th);
    in_vsync = 1'b1; in_href = bpix; in_data = 8'hff;
    step();
    chk("frame_valid", bbox_valid, 1'b1);
    chk_stats("close");
    in_href = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_data = 8'($urandom); step();
    end
    chk_stats("hold");
    in_vsync = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_href"}, out_href, 1'b0);
    chk({pfx, "_vsync"}, out_vsync, 1'b0);
    chk({pfx, "_data"}, out_data, 8'h00);
    chk({pfx, "_valid"}, bbox_valid, 1'b0);
    e_empty = 1; e_x0 = 0; e_x1 = 0; e_y0 = 0; e_y1 = 0; e_cnt = 0;
    chk_stats(pfx);
  endtask

  initial begin
    rst_n = 1'b0; in_href = 1'b0; in_vsync = 1'b0; in_data = '0; thresh = 8'd64;
    m_th = 8'(DEF_TH); m_vs_q = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // single edge pixel
    fill(8'd0); pix[2][5] = 8'd200;
    send_frame(4, -1, 8'd64, 0, 0);
    chk("t1_x0", bbox_x0, 5); chk("t1_y1", bbox_y1, 2);
    chk("t1_count", edge_count, 1); chk("t1_empty", bbox_empty, 0);

    // empty frame just below threshold
    fill(8'd63);
    send_frame(4, -1, 8'd64, 0, 0);
    chk("t2_empty", bbox_empty, 1); chk("t2_count", edge_count, 0);

    // full frame exactly at threshold
    fill(8'd64);
    send_frame(4, -1, 8'd64, 0, 0);
    chk("t3_x1", bbox_x1, 7); chk("t3_y1", bbox_y1, 3); chk("t3_count", edge_count, 32);

    // threshold change mid-frame applies from the next frame
    fill(8'd100);
    send_frame(4, 2, 8'd250, 0, 0);
    chk("t4a_count", edge_count, 32);
    send_frame(4, 1, 8'd64, 0, 0);
    chk("t4b_count", edge_count, 0); chk("t4b_empty", bbox_empty, 1);

    // long line: pixels past the last column are forwarded but not counted
    fill(8'd0); len[1] = 10; pix[1][8] = 8'd255; pix[1][9] = 8'd255;
    send_frame(4, -1, 8'd64, 0, 0);
    chk("t5_empty", bbox_empty, 1); chk("t5_count", edge_count, 0);

    // random frames, ragged lines, tight vsync and blanking pixels
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 4; l++) begin
        len[l] = $urandom_range(10, 1);
        for (int c = 0; c < 16; c++)
          pix[l][c] = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 140))
                                                  : 8'($urandom_range(120, 0));
      end
      send_frame($urandom_range(4, 1), $urandom_range(3, 0), 8'($urandom_range(200, 20)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // reset in the middle of a frame, with href high
    thresh = 8'd64;
    fill(8'd0); pix[0][1] = 8'd90; pix[3][6] = 8'd180;
    send_frame(4, -1, 8'd64, 0, 0);
    fill(8'd150);
    in_vsync = 1'b0;
    send_lines(0, 1);
    in_href = 1'b1; in_data = 8'd255;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    in_href = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    m_th = 8'(DEF_TH); m_vs_q = 1'b0;
    fill(8'd0); pix[1][2] = 8'd70; pix[1][7] = 8'd64; pix[2][0] = 8'd99;
    send_frame(4, -1, 8'd64, 0, 0);
    chk("t6_x0", bbox_x0, 0); chk("t6_x1", bbox_x1, 7);
    chk("t6_y0", bbox_y0, 1); chk("t6_y1", bbox_y1, 2); chk("t6_count", edge_count, 3);
    fill(8'd10); pix[3][3] = 8'd255;
    send_frame(4, -1, 8'd64, 0, 0);
    chk("t6b_count", edge_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vip_edge_bbox.md
Name: vip_edge_bbox

Overview:
- Downstream consumer of the Sobel gradient stream in the VIP chain.
- Binarises the gradient magnitude against a programmable threshold and forwards a 1-cycle-delayed binary video stream.
- Per frame, accumulates the edge-pixel count and the bounding box of all edge pixels. Results are latched at end of frame for the Nios II / Avalon-MM register block.

Parameters:
- BITS, 8: pixel/gradient width.
- WIDTH, 640: active pixels per line.
- HEIGHT, 480: active lines per frame.
- DEF_THRESH, 64: threshold value after reset.
- Derived localparams: XW = $clog2(WIDTH), YW = $clog2(HEIGHT), CW = $clog2(WIDTH*HEIGHT+1).

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_href  in  1  line-valid from the Sobel stage
- in_vsync  in  1  frame sync from the Sobel stage; high = vertical blanking
- in_data  in  BITS  gradient magnitude
- thresh  in  BITS  threshold from the register block; sampled once per frame
- out_href  out  1  in_href delayed 1 clk
- out_vsync  out  1  in_vsync delayed 1 clk
- out_data  out  BITS  all-ones if edge pixel, else 0; forced 0 when out_href=0
- bbox_valid  out  1  1-clk pulse when results update
- bbox_empty  out  1  1 = no edge pixel in the last frame
- bbox_x0 / bbox_x1  out  XW  min/max column of edge pixels, inclusive
- bbox_y0 / bbox_y1  out  YW  min/max line of edge pixels, inclusive
- edge_count  out  CW  number of edge pixels in the last frame

Behaviour:
- Reset (async, rst_n=0): clears all outputs, counters and delay regs to 0, sets bbox_empty=1, and loads th_q=DEF_THRESH.
- Edge test: edge = (in_data >= th_q). The comparison is unsigned.
- Stream path latency: exactly 1 clk.
  - out_href and out_vsync are registered copies of the inputs.
  - out_data = registered (edge & in_href) ? {BITS{1'b1}} : 0.
- Sync detection:
  - vs_q and hr_q are registered copies of in_vsync and in_href.
  - vs_rise = in_vsync & ~vs_q (end of frame).
  - hr_fall = ~in_href & hr_q (end of line).
- Column counter x:
  - Increments on each cycle with in_href=1 and in_vsync=0; clears on hr_fall.
  - Saturates at WIDTH-1. Pixels beyond WIDTH on a long line are still binarised and forwarded, but are excluded from the statistics.
- Line counter y:
  - Increments on hr_fall while in_vsync=0; saturates at HEIGHT-1.
  - Clears on vs_rise.
- Accumulate: when in_href=1, in_vsync=0, x<WIDTH (not yet past the saturation point) and edge=1:
  - count_acc += 1, saturating at WIDTH*HEIGHT.
  - If this is the first edge of the frame (found=0): load x0=x1=x, y0=y1=y, set found=1.
  - Otherwise: x0=min(x0,x), x1=max(x1,x), y0=min(y0,y), y1=max(y1,y).
- Frame close on vs_rise:
  - Copies the accumulators to the outputs; bbox_empty=~found; coordinates are forced to 0 when found=0.
  - Asserts bbox_valid for that single cycle.
  - Clears the accumulators, found, x and y.
  - Loads th_q<=thresh. The threshold is therefore constant within a frame, and changes to thresh mid-frame take effect from the next frame.
- Simultaneous events:
  - A pixel with in_href=1 in the vs_rise cycle is excluded from statistics, because in_vsync=1.
  - hr_fall coincident with vs_rise: the y clear wins.
- Pixels during blanking (in_vsync=1): forwarded, never counted.
- First frame after reset: the first vs_rise publishes whatever was accumulated since reset; software discards the first result.
- Reset mid-frame: the partial frame is lost, outputs return to reset values, and no bbox_valid is produced until the next vs_rise.
- Outputs bbox_* / edge_count hold their value between bbox_valid pulses.

Test Plan:
All cases use WIDTH=8, HEIGHT=4, BITS=8, with a vsync pulse separating frames.
1. Single edge pixel: one frame of zeros except in_data=200 at (x=5, y=2), thresh=64. Required: bbox_valid pulse at the next vs_rise with x0=x1=5, y0=y1=2, edge_count=1, bbox_empty=0; out_data=255 exactly 1 clk after that pixel, 0 elsewhere.
2. Empty frame: all in_data=63, thresh=64. Required: bbox_empty=1, all coordinates 0, edge_count=0; out_data is always 0.
3. Full frame and boundary: all in_data=64, thresh=64. Required: x0=0, x1=7, y0=0, y1=3, edge_count=32.
4. Threshold timing: change thresh from 64 to 250 mid-frame while all in_data=100. Required: the current frame reports edge_count=32; the next frame reports edge_count=0 and bbox_empty=1.
5. Long line: one line with 10 href cycles, in_data=255 at cycles 8 and 9 only. Required: out_data=255 on both pixels, but the frame reports bbox_empty=1 and edge_count=0.
6. Reset mid-frame: assert rst_n=0 for 3 clk halfway through frame 2. Required: all outputs 0 immediately (async), bbox_empty=1, no bbox_valid until the next vs_rise, and the next full frame reports correct results.
